// File: rtl/adder_checker.sv
// adder_checker: predicts {carry,sum} of a registered adder through a LATENCY-deep
// pipeline and scores the adder's outputs, capturing the first mismatch.
module adder_checker #(
    parameter int WIDTH       = 8,
    parameter int LATENCY     = 1,
    parameter int CNT_W       = 16,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] sum,
    input  logic             carry,
    input  logic             clear,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_flag,
    output logic [WIDTH:0]   err_exp,
    output logic [WIDTH:0]   err_got,
    output logic             busy,
    output logic             halted
);
    typedef enum logic {CHECK, HALTED} state_t;

    state_t             r_state, w_next;
    logic [LATENCY-1:0] r_vld;
    logic [WIDTH:0]     r_exp [LATENCY];
    logic [CNT_W-1:0]   r_pass, r_err;
    logic               r_flag;
    logic [WIDTH:0]     r_cap_exp, r_cap_got;
    logic [WIDTH:0]     w_got;
    logic               w_cmp, w_miss;

    assign w_got  = {carry, sum};
    // a comparison only counts when not clearing and not halted
    assign w_cmp  = r_vld[LATENCY-1] && !clear && r_state == CHECK;
    assign w_miss = r_exp[LATENCY-1] != w_got;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            for (int i = 0; i < LATENCY; i++) r_exp[i] <= '0;
        end else begin
            r_vld[0] <= en;
            r_exp[0] <= {1'b0, A} + {1'b0, B};
            for (int i = 1; i < LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_exp[i] <= r_exp[i-1];
            end
        end
    end

    always_comb begin
        w_next = r_state;
        if (clear) w_next = CHECK;
        else if (STOP_ON_ERR && w_cmp && w_miss) w_next = HALTED;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= CHECK;
            r_pass    <= '0;
            r_err     <= '0;
            r_flag    <= 1'b0;
            r_cap_exp <= '0;
            r_cap_got <= '0;
        end else begin
            r_state <= w_next;
            if (clear) begin
                r_pass    <= '0;
                r_err     <= '0;
                r_flag    <= 1'b0;
                r_cap_exp <= '0;
                r_cap_got <= '0;
            end else if (w_cmp) begin
                if (!w_miss && r_pass != '1) r_pass <= r_pass + CNT_W'(1);
                if (w_miss && r_err != '1) r_err <= r_err + CNT_W'(1);
                if (w_miss) r_flag <= 1'b1;
                if (w_miss && !r_flag) begin
                    r_cap_exp <= r_exp[LATENCY-1];
                    r_cap_got <= w_got;
                end
            end
        end
    end

    assign pass_cnt = r_pass;
    assign err_cnt  = r_err;
    assign err_flag = r_flag;
    assign err_exp  = r_cap_exp;
    assign err_got  = r_cap_got;
    assign busy     = |r_vld;
    assign halted   = r_state == HALTED;
endmodule

// File: tb/tb_adder_checker.sv
// tb_adder_checker: four checker configurations on one stimulus stream, scored
// against an operation-history reference model.
module tb_adder_checker;
    localparam int N = 4;
    localparam int LAT [N] = '{1, 1, 1, 2};
    localparam int CW  [N] = '{16, 16, 4, 16};
    localparam int STP [N] = '{0, 1, 0, 0};

    logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, clear = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic [8:0] flt = '0, d1 = '0, d2 = '0;
    logic [N-1:0][15:0] pc, ec;
    logic [3:0] pc2, ec2;
    logic [N-1:0] fl, bz, hl;
    logic [N-1:0][8:0] ex, gt;

    int vec = 0, errs = 0;
    int n = 0, rst_edge = 0;
    bit en_h [2048];
    logic [8:0] s_h [2048], g_h [2048];
    int m_pass [N], m_err [N];
    bit m_flag [N], m_halt [N], m_busy [N];
    logic [8:0] m_exp [N], m_got [N];

    always #5 clk = ~clk;

    // reference adders with optional fault, one and two clocks of latency
    always @(posedge clk) begin
        d1 <= ({1'b0, a} + {1'b0, b}) ^ flt;
        d2 <= d1;
    end

    adder_checker #(.LATENCY(1), .CNT_W(16), .STOP_ON_ERR(1'b0)) u0 (.clk(clk), .rst_n(rst_n), .en(en), .A(a), .B(b),
        .sum(d1[7:0]), .carry(d1[8]), .clear(clear), .pass_cnt(pc[0]), .err_cnt(ec[0]), .err_flag(fl[0]),
        .err_exp(ex[0]), .err_got(gt[0]), .busy(bz[0]), .halted(hl[0]));
    adder_checker #(.LATENCY(1), .CNT_W(16), .STOP_ON_ERR(1'b1)) u1 (.clk(clk), .rst_n(rst_n), .en(en), .A(a), .B(b),
        .sum(d1[7:0]), .carry(d1[8]), .clear(clear), .pass_cnt(pc[1]), .err_cnt(ec[1]), .err_flag(fl[1]),
        .err_exp(ex[1]), .err_got(gt[1]), .busy(bz[1]), .halted(hl[1]));
    adder_checker #(.LATENCY(1), .CNT_W(4), .STOP_ON_ERR(1'b0)) u2 (.clk(clk), .rst_n(rst_n), .en(en), .A(a), .B(b),
        .sum(d1[7:0]), .carry(d1[8]), .clear(clear), .pass_cnt(pc2), .err_cnt(ec2), .err_flag(fl[2]),
        .err_exp(ex[2]), .err_got(gt[2]), .busy(bz[2]), .halted(hl[2]));
    adder_checker #(.LATENCY(2), .CNT_W(16), .STOP_ON_ERR(1'b0)) u3 (.clk(clk), .rst_n(rst_n), .en(en), .A(a), .B(b),
        .sum(d2[7:0]), .carry(d2[8]), .clear(clear), .pass_cnt(pc[3]), .err_cnt(ec[3]), .err_flag(fl[3]),
        .err_exp(ex[3]), .err_got(gt[3]), .busy(bz[3]), .halted(hl[3]));

    assign pc[2] = {12'd0, pc2};
    assign ec[2] = {12'd0, ec2};

    task automatic model_reset();
        rst_edge = n;
        for (int i = 0; i < N; i++) begin
            m_pass[i] = 0; m_err[i] = 0; m_flag[i] = 0; m_halt[i] = 0; m_busy[i] = 0;
            m_exp[i] = '0; m_got[i] = '0;
        end
    endtask

    // drive one clock of stimulus; the model scores the operation issued LAT edges ago
    task automatic cyc(input logic e, input logic [7:0] x, input logic [7:0] y, input logic [8:0] f, input logic c);
        en = e; a = x; b = y; flt = f; clear = c;
        en_h[n] = e;
        s_h[n] = {1'b0, x} + {1'b0, y};
        g_h[n] = s_h[n] ^ f;
        for (int i = 0; i < N; i++) begin
            int k = n - LAT[i];
            int mx = (1 << CW[i]) - 1;
            if (c) begin
                m_pass[i] = 0; m_err[i] = 0; m_flag[i] = 0; m_halt[i] = 0; m_exp[i] = '0; m_got[i] = '0;
            end else if (!m_halt[i] && k >= rst_edge && en_h[k]) begin
                if (s_h[k] == g_h[k]) begin
                    if (m_pass[i] < mx) m_pass[i]++;
                end else begin
                    if (m_err[i] < mx) m_err[i]++;
                    if (!m_flag[i]) begin m_exp[i] = s_h[k]; m_got[i] = g_h[k]; end
                    m_flag[i] = 1;
                    if (STP[i] != 0) m_halt[i] = 1;
                end
            end
            m_busy[i] = 0;
            for (int j = k + 1; j <= n; j++) if (j >= rst_edge && en_h[j]) m_busy[i] = 1;
        end
        n++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            vec++; if (pc[i] !== 16'd0) begin errs++; $display("FAIL reset_pass[%0d] got %h want 0", i, pc[i]); end
            vec++; if (ec[i] !== 16'd0) begin errs++; $display("FAIL reset_err[%0d] got %h want 0", i, ec[i]); end
            vec++; if (fl[i] !== 1'b0) begin errs++; $display("FAIL reset_flag[%0d] got %b want 0", i, fl[i]); end
            vec++; if (ex[i] !== 9'd0 || gt[i] !== 9'd0) begin errs++; $display("FAIL reset_cap[%0d] got %h/%h want 0/0", i, ex[i], gt[i]); end
            vec++; if (bz[i] !== 1'b0 || hl[i] !== 1'b0) begin errs++; $display("FAIL reset_busy_halt[%0d] got %b%b want 00", i, bz[i], hl[i]); end
        end
    endtask

    task automatic test_idle();
        rst_n = 1'b1;
        repeat (10) cyc(0, 8'h00, 8'h00, 9'h000, 0);
        for (int i = 0; i < N; i++) begin
            vec++; if (pc[i] !== 16'd0 || ec[i] !== 16'd0) begin errs++; $display("FAIL idle_cnt[%0d] got %h/%h want 0/0", i, pc[i], ec[i]); end
            vec++; if (fl[i] !== 1'b0 || bz[i] !== 1'b0) begin errs++; $display("FAIL idle_flag_busy[%0d] got %b%b want 00", i, fl[i], bz[i]); end
        end
    endtask

    task automatic test_basic();
        cyc(1, 8'h0F, 8'h01, 9'h000, 0);
        cyc(0, 8'h00, 8'h00, 9'h000, 0);
        vec++; if (pc[0] !== 16'd1 || ec[0] !== 16'd0) begin errs++; $display("FAIL basic_l1 got %0d/%0d want 1/0", pc[0], ec[0]); end
        vec++; if (bz[0] !== 1'b0) begin errs++; $display("FAIL basic_busy_l1 got %b want 0", bz[0]); end
        vec++; if (pc[3] !== 16'd0 || bz[3] !== 1'b1) begin errs++; $display("FAIL basic_l2_pending got %0d/%b want 0/1", pc[3], bz[3]); end
        cyc(0, 8'h00, 8'h00, 9'h000, 0);
        vec++; if (pc[3] !== 16'd1 || bz[3] !== 1'b0) begin errs++; $display("FAIL basic_l2 got %0d/%b want 1/0", pc[3], bz[3]); end
    endtask

    task automatic test_carry_mismatch();
        cyc(1, 8'hFF, 8'h01, 9'h100, 0);
        repeat (2) cyc(0, 8'h00, 8'h00, 9'h000, 0);
        vec++; if (ec[0] !== 16'd1 || fl[0] !== 1'b1) begin errs++; $display("FAIL carry_err got %0d/%b want 1/1", ec[0], fl[0]); end
        vec++; if (ex[0] !== 9'h100 || gt[0] !== 9'h000) begin errs++; $display("FAIL carry_cap got %h/%h want 100/000", ex[0], gt[0]); end
        vec++; if (pc[0] !== 16'd1) begin errs++; $display("FAIL carry_pass got %0d want 1", pc[0]); end
        vec++; if (hl[1] !== 1'b1 || hl[0] !== 1'b0) begin errs++; $display("FAIL carry_halt got %b/%b want 1/0", hl[1], hl[0]); end
        vec++; if (ec[3] !== 16'd1 || ex[3] !== 9'h100) begin errs++; $display("FAIL carry_l2 got %0d/%h want 1/100", ec[3], ex[3]); end
        cyc(0, 8'h00, 8'h00, 9'h000, 1);
        for (int i = 0; i < N; i++) begin
            vec++;
            if (pc[i] !== 16'd0 || ec[i] !== 16'd0 || fl[i] !== 1'b0 || ex[i] !== 9'd0 || gt[i] !== 9'd0 || hl[i] !== 1'b0) begin
                errs++; $display("FAIL clear_all[%0d] got %h %h %b %h %h %b want all 0", i, pc[i], ec[i], fl[i], ex[i], gt[i], hl[i]);
            end
        end
    endtask

    task automatic test_halt();
        cyc(1, 8'h80, 8'h80, 9'h100, 0);
        cyc(1, 8'h01, 8'h01, 9'h001, 0);
        for (int i = 0; i < 3; i++) cyc(1, 8'(i + 5), 8'h22, 9'h000, 0);
        repeat (2) cyc(0, 8'h00, 8'h00, 9'h000, 0);
        vec++; if (ec[1] !== 16'd1 || pc[1] !== 16'd0) begin errs++; $display("FAIL halt_cnt got %0d/%0d want 1/0", ec[1], pc[1]); end
        vec++; if (hl[1] !== 1'b1) begin errs++; $display("FAIL halt_state got %b want 1", hl[1]); end
        vec++; if (ex[1] !== 9'h100 || gt[1] !== 9'h000) begin errs++; $display("FAIL halt_cap got %h/%h want 100/000", ex[1], gt[1]); end
        vec++; if (ec[0] !== 16'd2 || pc[0] !== 16'd3) begin errs++; $display("FAIL nohalt_cnt got %0d/%0d want 2/3", ec[0], pc[0]); end
        vec++; if (ex[0] !== 9'h100 || gt[0] !== 9'h000) begin errs++; $display("FAIL first_cap_kept got %h/%h want 100/000", ex[0], gt[0]); end
        cyc(0, 8'h00, 8'h00, 9'h000, 1);
        vec++; if (hl[1] !== 1'b0 || ec[1] !== 16'd0 || fl[1] !== 1'b0 || ex[1] !== 9'd0) begin
            errs++; $display("FAIL halt_clear got %b %h %b %h want 0 0 0 0", hl[1], ec[1], fl[1], ex[1]);
        end
    endtask

    task automatic test_back_to_back();
        repeat (20) cyc(1, 8'($urandom), 8'($urandom), 9'h000, 0);
        repeat (2) cyc(0, 8'h00, 8'h00, 9'h000, 0);
        vec++; if (pc[2] !== 16'h000F || ec[2] !== 16'd0) begin errs++; $display("FAIL saturate got %h/%h want 000f/0000", pc[2], ec[2]); end
        vec++; if (pc[0] !== 16'd20 || pc[1] !== 16'd20) begin errs++; $display("FAIL b2b_l1 got %0d/%0d want 20/20", pc[0], pc[1]); end
        vec++; if (pc[3] !== 16'd20 || ec[3] !== 16'd0) begin errs++; $display("FAIL b2b_l2 got %0d/%0d want 20/0", pc[3], ec[3]); end
    endtask

    task automatic test_clear_same_edge();
        cyc(1, 8'hFF, 8'h01, 9'h100, 0);
        cyc(0, 8'h00, 8'h00, 9'h000, 1);
        vec++; if (ec[0] !== 16'd0 || fl[0] !== 1'b0 || pc[0] !== 16'd0) begin
            errs++; $display("FAIL clear_wins got %h/%b/%h want 0/0/0", ec[0], fl[0], pc[0]);
        end
        vec++; if (hl[1] !== 1'b0) begin errs++; $display("FAIL clear_wins_halt got %b want 0", hl[1]); end
        cyc(0, 8'h00, 8'h00, 9'h000, 0);
        vec++; if (ec[3] !== 16'd1 || fl[3] !== 1'b1) begin errs++; $display("FAIL clear_then_l2 got %0d/%b want 1/1", ec[3], fl[3]); end
    endtask

    task automatic test_reset_corner();
        cyc(1, 8'h11, 8'h22, 9'h000, 0);
        cyc(1, 8'h33, 8'h44, 9'h000, 0);
        vec++; if (bz[3] !== 1'b1) begin errs++; $display("FAIL pending_before_rst got %b want 1", bz[3]); end
        en = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < N; i++) begin
            vec++; if (bz[i] !== 1'b0 || pc[i] !== 16'd0 || ec[i] !== 16'd0) begin
                errs++; $display("FAIL async_rst[%0d] got %b/%h/%h want 0/0/0", i, bz[i], pc[i], ec[i]);
            end
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) cyc(0, 8'h00, 8'h00, 9'h000, 0);
        vec++; if (pc[3] !== 16'd0 || ec[3] !== 16'd0 || bz[3] !== 1'b0) begin
            errs++; $display("FAIL after_rst got %h/%h/%b want 0/0/0", pc[3], ec[3], bz[3]);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 300; t++) begin
            cyc(($urandom % 4) != 0, 8'($urandom), 8'($urandom),
                ($urandom % 8) == 0 ? 9'($urandom) : 9'h000, ($urandom % 32) == 0);
            for (int i = 0; i < N; i++) begin
                vec++; if (pc[i] !== 16'(m_pass[i])) begin errs++; $display("FAIL rnd_pass[%0d] t=%0d got %0d want %0d", i, t, pc[i], m_pass[i]); end
                vec++; if (ec[i] !== 16'(m_err[i])) begin errs++; $display("FAIL rnd_err[%0d] t=%0d got %0d want %0d", i, t, ec[i], m_err[i]); end
                vec++; if (fl[i] !== m_flag[i] || hl[i] !== m_halt[i]) begin
                    errs++; $display("FAIL rnd_flag_halt[%0d] t=%0d got %b%b want %b%b", i, t, fl[i], hl[i], m_flag[i], m_halt[i]);
                end
                vec++; if (ex[i] !== m_exp[i] || gt[i] !== m_got[i]) begin
                    errs++; $display("FAIL rnd_cap[%0d] t=%0d got %h/%h want %h/%h", i, t, ex[i], gt[i], m_exp[i], m_got[i]);
                end
                vec++; if (bz[i] !== m_busy[i]) begin errs++; $display("FAIL rnd_busy[%0d] t=%0d got %b want %b", i, t, bz[i], m_busy[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_basic();
        test_carry_mismatch();
        test_halt();
        test_back_to_back();
        test_clear_same_edge();
        test_reset_corner();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule

// File: doc/adder_checker.md
# adder_checker

Self-checking result monitor for the registered 8-bit adder: samples the operands driven into the adder, predicts {carry, sum} through a pipeline matching the adder's latency, and compares the prediction against the adder's outputs. It counts passes and failures and captures the first mismatch. It sits in the adder testbench top beside the stimulus driver, on the same operand, result, clock and reset nets.

## Interface

Parameters:
- WIDTH, 8, operand and sum width.
- LATENCY, 1, adder latency in clocks from operand sample to result; legal range 1..4.
- CNT_W, 16, width of the pass and error counters.
- STOP_ON_ERR, 0, if 1 the checker halts counting after the first mismatch until clear.

Ports (one clock `clk`; reset `rst_n`, asynchronous, active-low):
- clk  in  1  rising-edge clock shared with the adder.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  A/B hold a valid operation this cycle.
- A  in  WIDTH  operand A, as driven to the adder.
- B  in  WIDTH  operand B, as driven to the adder.
- sum  in  WIDTH  adder sum output.
- carry  in  1  adder carry output.
- clear  in  1  synchronous clear of the counters, flags and captures.
- pass_cnt  out  CNT_W  number of matching comparisons, saturating.
- err_cnt  out  CNT_W  number of mismatching comparisons, saturating.
- err_flag  out  1  sticky flag, set on the first mismatch.
- err_exp  out  WIDTH+1  expected {carry,sum} of the first mismatch.
- err_got  out  WIDTH+1  observed {carry,sum} of the first mismatch.
- busy  out  1  at least one prediction is pending in the pipeline.
- halted  out  1  checker is in the HALTED state.

## Operation

- Prediction pipeline: LATENCY stages, each holding {vld, exp[WIDTH:0]}.
  - Stage 0 loads vld=en and exp=A+B, computed at WIDTH+1 bits with the MSB as the expected carry.
  - Each later stage copies the previous stage every clock.
- Compare point: the last stage with vld=1, compared against {carry,sum} sampled on the same edge.
  - On a match, pass_cnt increments.
  - On a mismatch, err_cnt increments and err_flag is set.
  - err_exp/err_got load only when err_flag was 0 before the edge; later mismatches never overwrite the capture.
- Counters saturate at 2^CNT_W-1; neither counter wraps.
- FSM, two states:
  - CHECK: normal counting.
  - HALTED: entered on the edge that records a mismatch when STOP_ON_ERR=1. In HALTED the pipeline keeps shifting, but comparisons do not change the counters or captures.
  - HALTED -> CHECK on clear=1. With STOP_ON_ERR=0 the FSM never leaves CHECK.
- clear:
  - Zeroes pass_cnt, err_cnt, err_flag, err_exp and err_got, and forces CHECK.
  - Does not flush the pipeline.
  - When a comparison lands on the same edge as clear, clear wins and that result is discarded.
- busy = OR of all stage vld bits.
- rst_n low, at any time: all vld bits, counters, flags and captures go to 0 and the FSM goes to CHECK. Pending predictions are discarded.

## Timing

- Reset values: pass_cnt=0, err_cnt=0, err_flag=0, err_exp=0, err_got=0, busy=0, halted=0.
- Operands sampled with en=1 at edge k are compared against sum/carry sampled at edge k+LATENCY. The updated counters are visible immediately after edge k+LATENCY.
- Back-to-back en=1 sustains one comparison per clock with no bubbles.
- All outputs are registered; there is no combinational path from any input to any output.
- Reset assertion is asynchronous. Deassertion must be synchronized externally to clk.
- en=0 cycles insert vld=0 bubbles. A bubble reaching the compare point produces no count change, whatever the sum/carry values.

## Test plan

- Idle after reset: rst_n released, en=0 for 10 clocks, adder outputs 0 -> pass_cnt=0, err_cnt=0, err_flag=0, busy=0.
- Basic match (LATENCY=1): en=1 with A=8'h0F, B=8'h01 at edge k, and a correct adder returning sum=8'h10, carry=0 -> pass_cnt=1 after edge k+1, err_cnt=0, busy=0 at k+2.
- Carry mismatch: A=8'hFF, B=8'h01, faulty adder returning sum=8'h00, carry=0 -> err_cnt=1, err_flag=1, err_exp=9'h100, err_got=9'h000.
- Capture and halt: with STOP_ON_ERR=1, a mismatch on A=8'h80, B=8'h80 is followed by a second mismatch and 3 matches -> err_cnt=1, pass_cnt unchanged, halted=1, capture still 9'h100/9'h000. After clear -> all zero, halted=0.
- Saturation: CNT_W=4, 20 consecutive matching operations -> pass_cnt=4'hF, err_cnt=0.
- Reset and clear corners:
  - rst_n pulsed low with 2 predictions pending (LATENCY=2) -> busy=0 and counters 0 immediately; no counts after release.
  - clear on the same edge as a mismatch -> err_cnt=0 and err_flag=0 after that edge.
